// File: rtl/axil_regfile_pkg.sv
// axil_pkg: shared types and helpers for the AXI4-Lite register file.
// Response codes, channel FSM state encodings and the address-to-word-index
// decode used by both the write and read channels.
package axil_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic {
        W_COLLECT = 1'b0,
        W_RESP    = 1'b1
    } wstate_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } rstate_t;

    // Widest address the decode helper accepts; callers zero-extend into it.
    localparam int MAX_ADDR_W = 64;

    // Drops the byte-offset bits so the result counts whole data words.
    function automatic logic [MAX_ADDR_W-1:0] word_index(
        input logic [MAX_ADDR_W-1:0] addr,
        input int unsigned           data_w
    );
        return (data_w == 64) ? (addr >> 3) : (addr >> 2);
    endfunction

endpackage

// File: rtl/axil_regfile_if.sv
// axil_regfile_if: the five AXI4-Lite channels bundled for the register file.
// The host side uses the master modport, the register file the slave modport.
interface axil_regfile_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   AWADDR;
    logic                AWVALID;
    logic                AWREADY;
    logic [DATA_W-1:0]   WDATA;
    logic [DATA_W/8-1:0] WSTRB;
    logic                WVALID;
    logic                WREADY;
    logic [1:0]          BRESP;
    logic                BVALID;
    logic                BREADY;
    logic [ADDR_W-1:0]   ARADDR;
    logic                ARVALID;
    logic                ARREADY;
    logic [DATA_W-1:0]   RDATA;
    logic [1:0]          RRESP;
    logic                RVALID;
    logic                RREADY;

    modport master (
        output AWADDR, AWVALID, input  AWREADY,
        output WDATA, WSTRB, WVALID, input WREADY,
        input  BRESP, BVALID, output BREADY,
        output ARADDR, ARVALID, input ARREADY,
        input  RDATA, RRESP, RVALID, output RREADY
    );

    modport slave (
        input  AWADDR, AWVALID, output AWREADY,
        input  WDATA, WSTRB, WVALID, output WREADY,
        output BRESP, BVALID, input BREADY,
        input  ARADDR, ARVALID, output ARREADY,
        output RDATA, RRESP, RVALID, input RREADY
    );
endinterface

// File: rtl/axil_regfile_store.sv
// axil_regfile_store: the register array behind the AXI-Lite channels.
// Holds NUM_REGS words, applies byte-strobe merging and read-only protection,
// and exposes every register on a flat bus.
// Build option AXIL_REGFILE_WSTRB_EN: when defined, only byte lanes with a set
// strobe are written; otherwise every accepted write replaces the whole word.
module axil_regfile_store #(
    parameter int                   DATA_W   = 32,
    parameter int                   NUM_REGS = 16,
    parameter int                   IDX_W    = 4,
    parameter logic [NUM_REGS-1:0]  RO_MASK  = '0,
    parameter logic [DATA_W-1:0]    RST_VAL  = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [IDX_W-1:0]           wr_idx,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [DATA_W/8-1:0]        wr_strb,
    output logic                       wr_ro,
    input  logic [IDX_W-1:0]           rd_idx,
    output logic [DATA_W-1:0]          rd_data,
    output logic [NUM_REGS*DATA_W-1:0] regs_o
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] merged;

    // Look up the protection bit of the register addressed by the write.
    always_comb begin
        wr_ro = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_idx == IDX_W'(i)) wr_ro = RO_MASK[i];
        end
    end

`ifdef AXIL_REGFILE_WSTRB_EN
    logic [DATA_W-1:0] cur;

    // Fetch the current word and overlay only the strobed byte lanes.
    always_comb begin
        cur = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_idx == IDX_W'(i)) cur = regs[i];
        end
        merged = cur;
        for (int b = 0; b < DATA_W/8; b++) begin
            if (wr_strb[b]) merged[b*8 +: 8] = wr_data[b*8 +: 8];
        end
    end
`else
    logic unused_strb;
    assign unused_strb = ^wr_strb;
    assign merged      = wr_data;
`endif

    // Register array: reset to RST_VAL, updated only on an accepted write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= RST_VAL;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_en && (wr_idx == IDX_W'(i))) regs[i] <= merged;
            end
        end
    end

    // Read mux; indices with no register behind them read as zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == IDX_W'(i)) rd_data = regs[i];
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_REGS; g++) begin : g_flat
            assign regs_o[g*DATA_W +: DATA_W] = regs[g];
        end
    endgenerate

endmodule

// File: rtl/axil_regfile.sv
// axil_regfile: parametrised AXI4-Lite slave register file.
// Owns the write channel FSM (W_COLLECT/W_RESP), the read channel FSM
// (R_IDLE/R_RESP) and address decode; storage lives in axil_regfile_store.
// Build option AXIL_REGFILE_WSTRB_EN selects byte-lane writes in the store.
module axil_regfile
    import axil_pkg::*;
#(
    parameter int                  ADDR_W   = 8,
    parameter int                  DATA_W   = 32,
    parameter int                  NUM_REGS = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK  = '0,
    parameter logic [DATA_W-1:0]   RST_VAL  = '0
) (
    input  logic                       ACLK,
    input  logic                       ARESET,
    axil_regfile_if.slave              bus,
    output logic [NUM_REGS*DATA_W-1:0] regs_o
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic                  bus_up;

    wstate_t               wstate;
    logic                  aw_full;
    logic                  w_full;
    logic [ADDR_W-1:0]     aw_addr;
    logic [DATA_W-1:0]     w_data;
    logic [DATA_W/8-1:0]   w_strb;
    resp_t                 bresp;
    logic                  bvalid;

    rstate_t               rstate;
    logic [DATA_W-1:0]     rdata;
    resp_t                 rresp;
    logic                  rvalid;

    logic [MAX_ADDR_W-1:0] aw_word;
    logic [MAX_ADDR_W-1:0] ar_word;
    logic                  aw_in_range;
    logic                  ar_in_range;
    logic                  aw_ready;
    logic                  w_ready;
    logic                  ar_ready;
    logic                  commit;
    logic                  wr_en;
    logic                  wr_ro;
    logic [DATA_W-1:0]     rd_data;

    assign aw_word     = word_index(MAX_ADDR_W'(aw_addr), DATA_W);
    assign ar_word     = word_index(MAX_ADDR_W'(bus.ARADDR), DATA_W);
    assign aw_in_range = aw_word < MAX_ADDR_W'(NUM_REGS);
    assign ar_in_range = ar_word < MAX_ADDR_W'(NUM_REGS);

    assign aw_ready = bus_up && (wstate == W_COLLECT) && !aw_full;
    assign w_ready  = bus_up && (wstate == W_COLLECT) && !w_full;
    assign ar_ready = bus_up && (rstate == R_IDLE);
    assign commit   = (wstate == W_COLLECT) && aw_full && w_full;
    assign wr_en    = commit && aw_in_range && !wr_ro;

    assign bus.AWREADY = aw_ready;
    assign bus.WREADY  = w_ready;
    assign bus.BVALID  = bvalid;
    assign bus.BRESP   = bresp;
    assign bus.ARREADY = ar_ready;
    assign bus.RVALID  = rvalid;
    assign bus.RRESP   = rresp;
    assign bus.RDATA   = rdata;

    // Keeps all readies low until the first clock edge after reset release.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) bus_up <= 1'b0;
        else        bus_up <= 1'b1;
    end

    // Write channel: collect AW and W independently, commit, then hold B.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wstate  <= W_COLLECT;
            aw_full <= 1'b0;
            w_full  <= 1'b0;
            aw_addr <= '0;
            w_data  <= '0;
            w_strb  <= '0;
            bvalid  <= 1'b0;
            bresp   <= OKAY;
        end else begin
            case (wstate)
                W_COLLECT: begin
                    if (aw_ready && bus.AWVALID) begin
                        aw_full <= 1'b1;
                        aw_addr <= bus.AWADDR;
                    end
                    if (w_ready && bus.WVALID) begin
                        w_full <= 1'b1;
                        w_data <= bus.WDATA;
                        w_strb <= bus.WSTRB;
                    end
                    if (commit) begin
                        bvalid <= 1'b1;
                        wstate <= W_RESP;
                        if (!aw_in_range)  bresp <= DECERR;
                        else if (wr_ro)    bresp <= SLVERR;
                        else               bresp <= OKAY;
                    end
                end
                W_RESP: begin
                    if (bus.BREADY) begin
                        bvalid  <= 1'b0;
                        aw_full <= 1'b0;
                        w_full  <= 1'b0;
                        wstate  <= W_COLLECT;
                    end
                end
                default: wstate <= W_COLLECT;
            endcase
        end
    end

    // Read channel: sample the addressed word on AR, hold R until accepted.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rstate <= R_IDLE;
            rvalid <= 1'b0;
            rresp  <= OKAY;
            rdata  <= '0;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (ar_ready && bus.ARVALID) begin
                        rvalid <= 1'b1;
                        rstate <= R_RESP;
                        if (ar_in_range) begin
                            rdata <= rd_data;
                            rresp <= OKAY;
                        end else begin
                            rdata <= '0;
                            rresp <= DECERR;
                        end
                    end
                end
                R_RESP: begin
                    if (bus.RREADY) begin
                        rvalid <= 1'b0;
                        rstate <= R_IDLE;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    axil_regfile_store #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W),
        .RO_MASK  (RO_MASK),
        .RST_VAL  (RST_VAL)
    ) u_store (
        .clk     (ACLK),
        .rst     (ARESET),
        .wr_en   (wr_en),
        .wr_idx  (aw_word[IDX_W-1:0]),
        .wr_data (w_data),
        .wr_strb (w_strb),
        .wr_ro   (wr_ro),
        .rd_idx  (ar_word[IDX_W-1:0]),
        .rd_data (rd_data),
        .regs_o  (regs_o)
    );

endmodule

// File: tb/tb_axil_regfile.sv
// tb_axil_regfile: directed, table-driven bench for axil_regfile with
// RO_MASK bit 3 set; hand-written sequences cover the multi-cycle timing cases.
module tb_axil_regfile;
    import axil_pkg::*;

`ifdef AXIL_REGFILE_WSTRB_EN
    localparam bit STRB_EN = 1'b1;
`else
    localparam bit STRB_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [16*32-1:0] regs;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        bit          is_write;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  exp_resp;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [15];

    always #5 clk = ~clk;

    axil_regfile_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    axil_regfile #(
        .ADDR_W   (8),
        .DATA_W   (32),
        .NUM_REGS (16),
        .RO_MASK  (16'h0008),
        .RST_VAL  (32'h0)
    ) dut (
        .ACLK   (clk),
        .ARESET (rst),
        .bus    (bus),
        .regs_o (regs)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] reg_at(input int i);
        return regs[i*32 +: 32];
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp, output bit done);
        bit aw_hs;
        bit w_hs;
        resp = 2'b00;
        done = 1'b0;
        bus.AWADDR  = addr;
        bus.AWVALID = 1'b1;
        bus.WDATA   = data;
        bus.WSTRB   = strb;
        bus.WVALID  = 1'b1;
        bus.BREADY  = 1'b1;
        for (int c = 0; c < 20 && (bus.AWVALID || bus.WVALID); c++) begin
            aw_hs = bus.AWVALID && bus.AWREADY;
            w_hs  = bus.WVALID && bus.WREADY;
            tick();
            if (aw_hs) bus.AWVALID = 1'b0;
            if (w_hs)  bus.WVALID  = 1'b0;
        end
        bus.AWVALID = 1'b0;
        bus.WVALID  = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            if (bus.BVALID) begin
                resp = bus.BRESP;
                done = 1'b1;
            end
            tick();
        end
        bus.BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [7:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output bit done);
        bit ar_hs;
        data = '0;
        resp = 2'b00;
        done = 1'b0;
        bus.ARADDR  = addr;
        bus.ARVALID = 1'b1;
        bus.RREADY  = 1'b1;
        for (int c = 0; c < 20 && bus.ARVALID; c++) begin
            ar_hs = bus.ARREADY;
            tick();
            if (ar_hs) bus.ARVALID = 1'b0;
        end
        bus.ARVALID = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            if (bus.RVALID) begin
                data = bus.RDATA;
                resp = bus.RRESP;
                done = 1'b1;
            end
            tick();
        end
        bus.RREADY = 1'b0;
    endtask

    task automatic apply_stimulus(input vec_t v, input int idx);
        logic [31:0] data;
        logic [1:0]  resp;
        bit          done;
        if (v.is_write) begin
            axi_write(v.addr, v.data, v.strb, resp, done);
            check_output($sformatf("vec%0d write done", idx), 32'(done), 32'd1);
            check_output($sformatf("vec%0d bresp", idx), 32'(resp), 32'(v.exp_resp));
        end else begin
            axi_read(v.addr, data, resp, done);
            check_output($sformatf("vec%0d read done", idx), 32'(done), 32'd1);
            check_output($sformatf("vec%0d rresp", idx), 32'(resp), 32'(v.exp_resp));
            check_output($sformatf("vec%0d rdata", idx), data, v.exp_data);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] data;
        logic [1:0]  resp;
        bit          done;
        bit          seen;

        bus.AWADDR  = '0;
        bus.AWVALID = 1'b0;
        bus.WDATA   = '0;
        bus.WSTRB   = '0;
        bus.WVALID  = 1'b0;
        bus.BREADY  = 1'b0;
        bus.ARADDR  = '0;
        bus.ARVALID = 1'b0;
        bus.RREADY  = 1'b0;

        vecs[0]  = '{1'b0, 8'h04, 32'h0,        4'h0,    OKAY,   32'h0};
        vecs[1]  = '{1'b1, 8'h04, 32'hAAAAAAAA, 4'hF,    OKAY,   32'h0};
        vecs[2]  = '{1'b0, 8'h04, 32'h0,        4'h0,    OKAY,   32'hAAAAAAAA};
        vecs[3]  = '{1'b1, 8'h08, 32'hFFFFFFFF, 4'hF,    OKAY,   32'h0};
        vecs[4]  = '{1'b1, 8'h0C, 32'h0000DEAD, 4'hF,    SLVERR, 32'h0};
        vecs[5]  = '{1'b0, 8'h0C, 32'h0,        4'h0,    OKAY,   32'h0};
        vecs[6]  = '{1'b1, 8'h40, 32'h12345678, 4'hF,    DECERR, 32'h0};
        vecs[7]  = '{1'b0, 8'h40, 32'h0,        4'h0,    DECERR, 32'h0};
        vecs[8]  = '{1'b1, 8'h10, 32'h00001234, 4'h0,    OKAY,   32'h0};
        vecs[9]  = '{1'b0, 8'h10, 32'h0,        4'h0,    OKAY,   STRB_EN ? 32'h0 : 32'h00001234};
        vecs[10] = '{1'b1, 8'h3D, 32'h00005555, 4'hF,    OKAY,   32'h0};
        vecs[11] = '{1'b0, 8'h3C, 32'h0,        4'h0,    OKAY,   32'h00005555};
        vecs[12] = '{1'b1, 8'h14, 32'hA1B2C3D4, 4'b1000, OKAY,   32'h0};
        vecs[13] = '{1'b0, 8'h17, 32'h0,        4'h0,    OKAY,   STRB_EN ? 32'hA1000000 : 32'hA1B2C3D4};
        vecs[14] = '{1'b0, 8'hFC, 32'h0,        4'h0,    DECERR, 32'h0};

        // Reset state
        tick();
        tick();
        check_output("reset readies", {29'h0, bus.AWREADY, bus.WREADY, bus.ARREADY}, 32'h0);
        check_output("reset valids", {30'h0, bus.BVALID, bus.RVALID}, 32'h0);
        check_output("reset regs_o any set", 32'(|regs), 32'h0);
        rst = 1'b0;
        #1;
        check_output("readies before first edge", {29'h0, bus.AWREADY, bus.WREADY, bus.ARREADY}, 32'h0);
        tick();
        check_output("readies after release", {29'h0, bus.AWREADY, bus.WREADY, bus.ARREADY}, 32'h7);
        check_output("reset rdata", bus.RDATA, 32'h0);
        check_output("reset bresp/rresp", {28'h0, bus.BRESP, bus.RRESP}, 32'h0);

        for (int i = 0; i <= 3; i++) apply_stimulus(vecs[i], i);

        // AW and W in the same cycle, then B held off for 5 cycles
        bus.AWADDR = 8'h18; bus.AWVALID = 1'b1;
        bus.WDATA = 32'h0000600D; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
        bus.BREADY = 1'b0;
        tick();
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
        check_output("same-cycle bvalid after 1 edge", 32'(bus.BVALID), 32'h0);
        check_output("same-cycle reg6 before commit", reg_at(6), 32'h0);
        tick();
        check_output("same-cycle bvalid after 2 edges", 32'(bus.BVALID), 32'h1);
        check_output("same-cycle reg6 after commit", reg_at(6), 32'h0000600D);
        for (int k = 0; k < 5; k++) begin
            check_output($sformatf("b stall %0d {bvalid,bresp,awready,wready}", k),
                         {27'h0, bus.BVALID, bus.BRESP, bus.AWREADY, bus.WREADY}, 32'h10);
            tick();
        end
        bus.BREADY = 1'b1;
        tick();
        bus.BREADY = 1'b0;
        check_output("b release {bvalid,awready,wready}", {29'h0, bus.BVALID, bus.AWREADY, bus.WREADY}, 32'h3);
        tick();
        check_output("b single completion", 32'(bus.BVALID), 32'h0);

        // W three cycles before AW, byte strobes 0101 over all-ones
        bus.WDATA = 32'h12345678; bus.WSTRB = 4'b0101; bus.WVALID = 1'b1; bus.BREADY = 1'b0;
        tick();
        bus.WVALID = 1'b0;
        check_output("w-first wready after capture", 32'(bus.WREADY), 32'h0);
        tick();
        tick();
        check_output("w-first bvalid while waiting for aw", 32'(bus.BVALID), 32'h0);
        bus.AWADDR = 8'h08; bus.AWVALID = 1'b1;
        tick();
        bus.AWVALID = 1'b0;
        check_output("w-first bvalid at aw capture", 32'(bus.BVALID), 32'h0);
        check_output("w-first reg2 before commit", reg_at(2), 32'hFFFFFFFF);
        tick();
        check_output("w-first bvalid after commit", 32'(bus.BVALID), 32'h1);
        check_output("w-first reg2", reg_at(2), STRB_EN ? 32'hFF34FF78 : 32'h12345678);
        bus.BREADY = 1'b1;
        tick();
        bus.BREADY = 1'b0;
        axi_read(8'h08, data, resp, done);
        check_output("w-first readback", data, STRB_EN ? 32'hFF34FF78 : 32'h12345678);

        // Read captured on the same edge as a write commit to that register
        bus.AWADDR = 8'h24; bus.AWVALID = 1'b1;
        bus.WDATA = 32'h00000099; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
        tick();
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
        bus.ARADDR = 8'h24; bus.ARVALID = 1'b1; bus.RREADY = 1'b0;
        tick();
        bus.ARVALID = 1'b0;
        check_output("raw same edge rdata is old value", bus.RDATA, 32'h0);
        check_output("raw same edge {bvalid,rvalid}", {30'h0, bus.BVALID, bus.RVALID}, 32'h3);
        check_output("raw same edge reg9 new value", reg_at(9), 32'h00000099);
        bus.BREADY = 1'b1; bus.RREADY = 1'b1;
        tick();
        bus.BREADY = 1'b0; bus.RREADY = 1'b0;

        for (int i = 4; i <= 14; i++) apply_stimulus(vecs[i], i);
        check_output("reg3 read-only untouched", reg_at(3), 32'h0);

        // R held off for 5 cycles
        bus.ARADDR = 8'h04; bus.ARVALID = 1'b1; bus.RREADY = 1'b0;
        check_output("r stall arready before", 32'(bus.ARREADY), 32'h1);
        tick();
        bus.ARVALID = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check_output($sformatf("r stall %0d {rvalid,rresp,arready}", k),
                         {28'h0, bus.RVALID, bus.RRESP, bus.ARREADY}, 32'h8);
            check_output($sformatf("r stall %0d rdata", k), bus.RDATA, 32'hAAAAAAAA);
            tick();
        end
        bus.RREADY = 1'b1;
        tick();
        bus.RREADY = 1'b0;
        check_output("r release {rvalid,arready}", {30'h0, bus.RVALID, bus.ARREADY}, 32'h1);
        tick();
        check_output("r single completion", 32'(bus.RVALID), 32'h0);

        // Reset after AW accepted but before W arrives
        bus.AWADDR = 8'h1C; bus.AWVALID = 1'b1;
        tick();
        bus.AWVALID = 1'b0;
        rst = 1'b1;
        #1;
        check_output("mid reset readies", {29'h0, bus.AWREADY, bus.WREADY, bus.ARREADY}, 32'h0);
        check_output("mid reset bvalid", 32'(bus.BVALID), 32'h0);
        check_output("mid reset regs cleared", 32'(|regs), 32'h0);
        tick();
        rst = 1'b0;
        tick();
        check_output("post reset readies", {29'h0, bus.AWREADY, bus.WREADY, bus.ARREADY}, 32'h7);
        bus.WDATA = 32'h00000077; bus.WSTRB = 4'hF; bus.WVALID = 1'b1; bus.BREADY = 1'b1;
        tick();
        bus.WVALID = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (bus.BVALID) seen = 1'b1;
            tick();
        end
        check_output("dropped aw: bvalid never rises", 32'(seen), 32'h0);
        check_output("dropped aw: reg7 unchanged", reg_at(7), 32'h0);
        bus.AWADDR = 8'h1C; bus.AWVALID = 1'b1;
        tick();
        bus.AWVALID = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 10 && !done; c++) begin
            if (bus.BVALID) begin
                resp = bus.BRESP;
                done = 1'b1;
            end
            tick();
        end
        bus.BREADY = 1'b0;
        check_output("post reset write completes", 32'(done), 32'h1);
        check_output("post reset reg7", reg_at(7), 32'h00000077);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
